// File: rtl/uart_tx.sv
// UART transmitter: 8N1-style framing (one start bit, DATA_WIDTH data bits
// LSB first, one stop bit), each bit held for CLK_FREQ/BAUD_RATE clock cycles.
//
// Ports:
//   clk   - system clock, rising edge
//   rstn  - asynchronous active-low reset
//   data  - payload, captured only when valid && ready on a rising edge
//   valid - upstream offers data
//   ready - high only while idle (decoded from registered state)
//   sig   - registered serial line, idles high
module uart_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  sig
);

  localparam int unsigned PulseWidth = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntWidth   = $clog2(PulseWidth);
  localparam int unsigned IdxWidth   = $clog2(DATA_WIDTH);

  localparam logic [CntWidth-1:0] BaudLast = CntWidth'(PulseWidth - 1);
  localparam logic [IdxWidth-1:0] BitLast  = IdxWidth'(DATA_WIDTH - 1);
  localparam logic [CntWidth-1:0] BaudOne  = CntWidth'(1);
  localparam logic [IdxWidth-1:0] BitOne   = IdxWidth'(1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   baud_cnt_q, baud_cnt_d;
  logic [IdxWidth-1:0]   bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  sig_q, sig_d;
  logic                  baud_done;

  assign baud_done = (baud_cnt_q == BaudLast);

  // sig_d is derived from the state being entered so the line changes on the
  // same edge as the state, giving a one-cycle latency from acceptance.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    sig_d      = sig_q;

    case (state_q)
      StIdle: begin
        sig_d = 1'b1;
        if (valid) begin
          state_d    = StStart;
          shift_d    = data;
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          sig_d      = 1'b0;
        end
      end

      StStart: begin
        if (baud_done) begin
          state_d    = StData;
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          sig_d      = shift_q[0];
        end else begin
          baud_cnt_d = baud_cnt_q + BaudOne;
        end
      end

      StData: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          if (bit_idx_q == BitLast) begin
            state_d   = StStop;
            bit_idx_d = '0;
            sig_d     = 1'b1;
          end else begin
            // Shift right so the next bit to send always sits at shift_q[0].
            bit_idx_d = bit_idx_q + BitOne;
            shift_d   = shift_q >> 1;
            sig_d     = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BaudOne;
        end
      end

      StStop: begin
        sig_d = 1'b1;
        if (baud_done) begin
          state_d    = StIdle;
          baud_cnt_d = '0;
          bit_idx_d  = '0;
        end else begin
          baud_cnt_d = baud_cnt_q + BaudOne;
        end
      end

      default: begin
        state_d    = StIdle;
        baud_cnt_d = '0;
        bit_idx_d  = '0;
        sig_d      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      sig_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      sig_q      <= sig_d;
    end
  end

  assign ready = (state_q == StIdle);
  assign sig   = sig_q;

endmodule
